// File: rtl/mux_scan_sequencer.sv
// Scan controller for the 7:1 select mux: steps MuxSelect through channels 0..6,
// samples MuxOut on the last dwell cycle of each channel and publishes a 7-bit word.
module mux_scan_sequencer #(
  parameter int RATE_DIV = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       Continuous,
  input  logic       MuxOut,
  output logic [2:0] MuxSelect,
  output logic [6:0] Sampled,
  output logic       Done,
  output logic       Busy,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] RELOAD = 8'(RATE_DIV - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] buf_q, buf_d;
  logic [6:0] sampled_q, sampled_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    sampled_d = sampled_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        sel_d = 3'd0;
        if (Start) begin
          state_d = S_SCAN;
          cnt_d   = RELOAD;
          buf_d   = 7'd0;
        end
      end
      S_SCAN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          buf_d[sel_q] = MuxOut;
          // Last channel: publish the completed word together with the Done pulse.
          if (sel_q == 3'd6) begin
            state_d   = S_DONE;
            sampled_d = buf_d;
            done_d    = 1'b1;
          end else begin
            sel_d = sel_q + 3'd1;
            cnt_d = RELOAD;
          end
        end
      end
      S_DONE: begin
        sel_d = 3'd0;
        if (Continuous) begin
          state_d = S_SCAN;
          cnt_d   = RELOAD;
          buf_d   = 7'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = 3'd0;
      end
    endcase
    busy_d = (state_d == S_SCAN);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      sel_q     <= 3'd0;
      cnt_q     <= 8'd0;
      buf_q     <= 7'd0;
      sampled_q <= 7'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      sampled_q <= sampled_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign MuxSelect = sel_q;
  assign Sampled   = sampled_q;
  assign Done      = done_q;
  assign Busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (dwell 4 and dwell 1) with mux models,
// expected words/Done cycles queued at stimulus time and checked by monitors.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance a: dwell 4
  logic       start_a = 1'b0, cont_a = 1'b0, mux_out_a;
  logic       mode_a = 1'b0, glitch_val_a = 1'b0;
  logic [6:0] pattern_a = 7'd0;
  logic [2:0] sel_a;
  logic [6:0] sampled_a;
  logic       done_a, busy_a;
  logic [1:0] dbg_a;

  // Instance b: dwell 1
  logic       start_b = 1'b0, cont_b = 1'b0, mux_out_b;
  logic [6:0] pattern_b = 7'd0;
  logic [2:0] sel_b;
  logic [6:0] sampled_b;
  logic       done_b, busy_b;
  logic [1:0] dbg_b;

  always_comb mux_out_a = mode_a ? glitch_val_a : pattern_a[sel_a];
  always_comb mux_out_b = pattern_b[sel_b];

  mux_scan_sequencer #(.RATE_DIV(4)) u_dut_a (
    .Clock(clk), .Resetn(rst_n), .Start(start_a), .Continuous(cont_a), .MuxOut(mux_out_a),
    .MuxSelect(sel_a), .Sampled(sampled_a), .Done(done_a), .Busy(busy_a), .dbg_state(dbg_a)
  );

  mux_scan_sequencer #(.RATE_DIV(1)) u_dut_b (
    .Clock(clk), .Resetn(rst_n), .Start(start_b), .Continuous(cont_b), .MuxOut(mux_out_b),
    .MuxSelect(sel_b), .Sampled(sampled_b), .Done(done_b), .Busy(busy_b), .dbg_state(dbg_b)
  );

  logic [6:0] exp_a_q[$];
  int         exp_a_cyc_q[$];
  logic [6:0] exp_b_q[$];
  int         exp_b_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_start_a(output int c0);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    c0 = cyc;
  endtask

  task automatic pulse_start_b(output int c0);
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    c0 = cyc;
  endtask

  // Monitors: Done pops one expected (word, cycle); otherwise Sampled must hold.
  logic [6:0] last_a = 7'd0;
  logic [6:0] last_b = 7'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_a = 7'd0;
    end else if (done_a) begin
      if (exp_a_q.size() == 0) begin
        check("done_a_unexpected", 32'd1, 32'd0);
        last_a = sampled_a;
      end else begin
        check("sampled_a", 32'(sampled_a), 32'(exp_a_q[0]));
        check("done_a_cycle", cyc, exp_a_cyc_q[0]);
        check("busy_a_in_done", 32'(busy_a), 32'd0);
        last_a = exp_a_q.pop_front();
        void'(exp_a_cyc_q.pop_front());
      end
    end else begin
      check("sampled_a_hold", 32'(sampled_a), 32'(last_a));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_b = 7'd0;
    end else if (done_b) begin
      if (exp_b_q.size() == 0) begin
        check("done_b_unexpected", 32'd1, 32'd0);
        last_b = sampled_b;
      end else begin
        check("sampled_b", 32'(sampled_b), 32'(exp_b_q[0]));
        check("done_b_cycle", cyc, exp_b_cyc_q[0]);
        last_b = exp_b_q.pop_front();
        void'(exp_b_cyc_q.pop_front());
      end
    end else begin
      check("sampled_b_hold", 32'(sampled_b), 32'(last_b));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [6:0] pat;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sel_a", 32'(sel_a), 32'd0);
    check("rst_sampled_a", 32'(sampled_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_sel_a", 32'(sel_a), 32'd0);
    check("idle_busy_a", 32'(busy_a), 32'd0);
    check("idle_sel_b", 32'(sel_b), 32'd0);
    check("idle_busy_b", 32'(busy_b), 32'd0);

    // Single scan, dwell 4: channel stepping, Busy span, Done at cycle 29
    pattern_a = 7'b1010011;
    pulse_start_a(c0);
    exp_a_q.push_back(7'b1010011);
    exp_a_cyc_q.push_back(c0 + 28);
    for (int k = 0; k < 7; k++) begin
      wait_cyc(c0 + 4 * k);
      check("step_sel_first", 32'(sel_a), k);
      check("step_busy", 32'(busy_a), 32'd1);
      wait_cyc(c0 + 4 * k + 3);
      check("step_sel_last", 32'(sel_a), k);
    end
    wait_cyc(c0 + 28);
    check("busy_off_at_done", 32'(busy_a), 32'd0);
    wait_cyc(c0 + 29);
    check("after_scan_sel", 32'(sel_a), 32'd0);
    check("after_scan_busy", 32'(busy_a), 32'd0);
    check("single_done", 32'(done_a), 32'd0);
    check("scan1_queue_empty", exp_a_q.size(), 32'd0);

    // Start re-asserted mid-scan is ignored
    pat = 7'($urandom_range(0, 127));
    pattern_a = pat;
    pulse_start_a(c0);
    exp_a_q.push_back(pat);
    exp_a_cyc_q.push_back(c0 + 28);
    wait_cyc(c0 + 9);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_cyc(c0 + 40);
    check("restart_queue_empty", exp_a_q.size(), 32'd0);
    check("restart_idle_busy", 32'(busy_a), 32'd0);

    // Reset mid-scan discards the partial word and clears Sampled
    pattern_a = 7'($urandom_range(0, 127));
    pulse_start_a(c0);
    exp_a_q.push_back(pattern_a);
    exp_a_cyc_q.push_back(c0 + 28);
    wait_cyc(c0 + 14);
    #2;
    rst_n = 1'b0;
    exp_a_q.delete();
    exp_a_cyc_q.delete();
    #1;
    check("midrst_sel", 32'(sel_a), 32'd0);
    check("midrst_sampled", 32'(sampled_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    pat = 7'($urandom_range(1, 127));
    pattern_a = pat;
    pulse_start_a(c0);
    exp_a_q.push_back(pat);
    exp_a_cyc_q.push_back(c0 + 28);
    wait_cyc(c0 + 30);
    check("post_rst_queue_empty", exp_a_q.size(), 32'd0);

    // MuxOut toggles except on final dwell cycles, where it is 1
    mode_a = 1'b1;
    glitch_val_a = 1'b0;
    pulse_start_a(c0);
    exp_a_q.push_back(7'b1111111);
    exp_a_cyc_q.push_back(c0 + 28);
    for (int off = 0; off < 28; off++) begin
      glitch_val_a = ((off % 4) == 3) ? 1'b1 : 1'(off % 2);
      @(negedge clk);
    end
    glitch_val_a = 1'b0;
    wait_cyc(c0 + 30);
    mode_a = 1'b0;
    check("glitch_queue_empty", exp_a_q.size(), 32'd0);

    // Continuous dropped during the second scan: two Done pulses, then IDLE
    pat = 7'($urandom_range(0, 127));
    pattern_a = pat;
    cont_a = 1'b1;
    pulse_start_a(c0);
    exp_a_q.push_back(pat);
    exp_a_cyc_q.push_back(c0 + 28);
    exp_a_q.push_back(pat);
    exp_a_cyc_q.push_back(c0 + 57);
    wait_cyc(c0 + 33);
    cont_a = 1'b0;
    wait_cyc(c0 + 62);
    check("cont_drop_sel", 32'(sel_a), 32'd0);
    check("cont_drop_busy", 32'(busy_a), 32'd0);
    wait_cyc(c0 + 100);
    check("cont_drop_queue_empty", exp_a_q.size(), 32'd0);

    // Dwell 1, continuous: Done every 8 cycles, pattern change picked up by next full scan
    pattern_b = 7'b0111100;
    cont_b = 1'b1;
    pulse_start_b(c0);
    exp_b_q.push_back(7'b0111100); exp_b_cyc_q.push_back(c0 + 7);
    exp_b_q.push_back(7'b0111100); exp_b_cyc_q.push_back(c0 + 15);
    exp_b_q.push_back(7'b1000001); exp_b_cyc_q.push_back(c0 + 23);
    exp_b_q.push_back(7'b1000001); exp_b_cyc_q.push_back(c0 + 31);
    wait_cyc(c0 + 3);
    check("b_busy_mid", 32'(busy_b), 32'd1);
    check("b_sel_mid", 32'(sel_b), 32'd3);
    wait_cyc(c0 + 15);
    pattern_b = 7'b1000001;
    wait_cyc(c0 + 26);
    cont_b = 1'b0;
    wait_cyc(c0 + 36);
    check("b_end_sel", 32'(sel_b), 32'd0);
    check("b_end_busy", 32'(busy_b), 32'd0);
    check("b_queue_empty", exp_b_q.size(), 32'd0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
